// File: rtl/fcs32_tx_64.sv
// Ethernet FCS generator for a 64-bit byte stream: computes CRC-32 over the
// payload and appends the 4-byte FCS in the last beat or one extra trailing beat.
module fcs32_tx_64 (
    input  logic        pclk_i,
    input  logic        rst_i,
    input  logic [63:0] dat_i,
    input  logic [2:0]  mod_i,
    input  logic        sof_i,
    input  logic        eof_i,
    input  logic        val_i,
    output logic        rdy_o,
    output logic [63:0] dat_o,
    output logic [2:0]  mod_o,
    output logic        sof_o,
    output logic        eof_o,
    output logic        val_o,
    input  logic        rdy_i,
    output logic        err_o
);
    typedef enum logic [1:0] {IDLE, FRAME, TAIL} state_t;

    state_t      state;
    logic [31:0] crc;
    logic [63:0] tail_dat_p1;
    logic [2:0]  tail_mod_p1;

    // CRC state is held in reflected (LSB-first) form, one byte at a time.
    function automatic logic [31:0] fcs32_8(input logic [7:0] d, input logic [31:0] c);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [31:0] fcs32_16(input logic [15:0] d, input logic [31:0] c);
        return fcs32_8(d[7:0], fcs32_8(d[15:8], c));
    endfunction

    function automatic logic [31:0] fcs32_32(input logic [31:0] d, input logic [31:0] c);
        return fcs32_16(d[15:0], fcs32_16(d[31:16], c));
    endfunction

    function automatic logic [31:0] fcs32_64(input logic [63:0] d, input logic [31:0] c);
        return fcs32_32(d[31:0], fcs32_32(d[63:32], c));
    endfunction

    // With a reflected state, the wire-order FCS is the inverted CRC in reversed byte order.
    function automatic logic [31:0] fcs32_brev(input logic [31:0] c);
        logic [31:0] x;
        x = ~c;
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    logic         adv, acc;
    logic [3:0]   n;
    logic [31:0]  crc_in, crc_nxt, fcs;
    logic [63:0]  part, keep, pay;
    logic [127:0] wide;

    assign adv   = !val_o || rdy_i;
    assign rdy_o = !rst_i && (state != TAIL) && adv;
    assign acc   = val_i && rdy_o;

    always_comb begin
        n       = (eof_i && mod_i != 3'd0) ? {1'b0, mod_i} : 4'd8;
        crc_in  = sof_i ? 32'hFFFF_FFFF : crc;
        crc_nxt = crc_in;
        part    = dat_i;
        if (n == 4'd8) begin
            crc_nxt = fcs32_64(dat_i, crc_in);
        end else begin
            if (n[2]) begin
                crc_nxt = fcs32_32(part[63:32], crc_nxt);
                part    = part << 32;
            end
            if (n[1]) begin
                crc_nxt = fcs32_16(part[63:48], crc_nxt);
                part    = part << 16;
            end
            if (n[0])
                crc_nxt = fcs32_8(part[63:56], crc_nxt);
        end
        fcs  = fcs32_brev(crc_nxt);
        keep = (n == 4'd8) ? {64{1'b1}} : ~({64{1'b1}} >> {n[2:0], 3'b000});
        pay  = dat_i & keep;
        // Upper half is the last beat, lower half the spill-over beat when n >= 5.
        wide = {pay, 64'h0} | ({fcs, 96'h0} >> {n, 3'b000});
    end

    // Output register stage
    always_ff @(posedge pclk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            crc   <= 32'hFFFF_FFFF;
            dat_o <= 64'h0;
            mod_o <= 3'd0;
            sof_o <= 1'b0;
            eof_o <= 1'b0;
            val_o <= 1'b0;
            err_o <= 1'b0;
        end else begin
            err_o <= acc && ((state == IDLE && !sof_i) || (state == FRAME && sof_i));
            if (acc) begin
                if (state == IDLE && !sof_i) begin
                    val_o <= 1'b0;
                end else begin
                    crc   <= crc_nxt;
                    val_o <= 1'b1;
                    sof_o <= sof_i;
                    if (!eof_i) begin
                        dat_o <= dat_i;
                        mod_o <= 3'd0;
                        eof_o <= 1'b0;
                        state <= FRAME;
                    end else if (n <= 4'd4) begin
                        dat_o <= wide[127:64];
                        mod_o <= n[2:0] + 3'd4;
                        eof_o <= 1'b1;
                        state <= IDLE;
                    end else begin
                        dat_o <= wide[127:64];
                        mod_o <= 3'd0;
                        eof_o <= 1'b0;
                        state <= TAIL;
                    end
                end
            end else if (state == TAIL && adv) begin
                dat_o <= tail_dat_p1;
                mod_o <= tail_mod_p1;
                sof_o <= 1'b0;
                eof_o <= 1'b1;
                val_o <= 1'b1;
                state <= IDLE;
            end else if (adv) begin
                val_o <= 1'b0;
            end
        end
    end

    always_ff @(posedge pclk_i) begin
        if (acc && eof_i && n > 4'd4) begin
            tail_dat_p1 <= wide[63:0];
            tail_mod_p1 <= n[2:0] - 3'd4;
        end
    end
endmodule
